fetch_pc_gen: RTL

Fetch-address generator directly upstream of the IFU fetch-request buffer. Produces one fetch block per cycle: a word-aligned PC plus cut_pos, which gives the instruction count to the end of the 16-byte group. Applies backend redirects, handles IFU backpressure and global stall, and supports an idle/halt state. With FETCH_BTB_EN defined, it also provides a small direct-mapped BTB for taken-branch steering.

---
 rtl/fetch_if.sv | 18 +
 rtl/fetch_pc_gen.sv | 136 +++++++++++++
 2 files changed

// File: rtl/fetch_if.sv
// Fetch-block handshake between the PC generator and the IFU
// request buffer.
interface fetch_if;
   logic [31:0] fetch_pc;
   logic [1:0]  cut_pos;
   logic        pc_valid;
   logic        ifu_ready;

   modport master (
      output fetch_pc, cut_pos, pc_valid,
      input  ifu_ready
   );

   modport slave (
      input  fetch_pc, cut_pos, pc_valid,
      output ifu_ready
   );
endinterface

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: one 16B-group block per cycle.
// FETCH_BTB_EN adds a direct-mapped BTB for taken-branch steering.
module fetch_pc_gen #(
   parameter logic [31:0] RESET_PC    = 32'h1c00_0000,
   parameter int          BTB_ENTRIES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt_req,
`ifdef FETCH_BTB_EN
   input  logic        btb_upd_valid,
   input  logic [31:0] btb_upd_pc,
   input  logic [31:0] btb_upd_target,
`endif
   output logic [31:0] blk_cnt,
   fetch_if.master     f
);

   typedef enum logic [1:0] {
      S_BOOT,
      S_RUN,
      S_HALT
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] w_pc_nxt;
   logic [31:0] r_blk_cnt;
   logic [31:0] w_cnt_nxt;

   logic        w_pc_valid;
   logic        w_accept;
   logic [1:0]  w_cut;
   logic [31:0] w_adv_pc;
   logic [1:0]  w_unused_bits;

   assign w_pc_valid = (r_state == S_RUN) && !redirect_valid && !stall;
   assign w_accept   = w_pc_valid && f.ifu_ready;

`ifdef FETCH_BTB_EN
   localparam int IW = $clog2(BTB_ENTRIES);
   localparam int TW = 28 - IW;

   logic [BTB_ENTRIES-1:0] r_btb_v;
   logic [TW-1:0]          r_btb_tag [BTB_ENTRIES];
   logic [1:0]             r_btb_slot [BTB_ENTRIES];
   logic [29:0]            r_btb_tgt [BTB_ENTRIES];

   logic [IW-1:0] w_rd_idx;
   logic [IW-1:0] w_wr_idx;
   logic          w_hit;

   assign w_rd_idx = r_pc[4+IW-1:4];
   assign w_wr_idx = btb_upd_pc[4+IW-1:4];

   assign w_hit = r_btb_v[w_rd_idx]
               && (r_btb_tag[w_rd_idx] == r_pc[31:4+IW])
               && (r_btb_slot[w_rd_idx] >= r_pc[3:2]);

   // Taken branch cuts the block after its slot
   assign w_cut = w_hit
      ? (r_btb_slot[w_rd_idx] - r_pc[3:2] + 2'd1)
      : (2'd0 - r_pc[3:2]);

   assign w_adv_pc = w_hit
      ? {r_btb_tgt[w_rd_idx], 2'b00}
      : {r_pc[31:4] + 28'd1, 4'b0000};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_btb_v <= '0;
      end else if (btb_upd_valid) begin
         r_btb_v[w_wr_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (btb_upd_valid) begin
         r_btb_tag[w_wr_idx]  <= btb_upd_pc[31:4+IW];
         r_btb_slot[w_wr_idx] <= btb_upd_pc[3:2];
         r_btb_tgt[w_wr_idx]  <= btb_upd_target[31:2];
      end
   end

   assign w_unused_bits = redirect_pc[1:0]
                        ^ btb_upd_pc[1:0]
                        ^ btb_upd_target[1:0];
`else
   assign w_cut    = 2'd0 - r_pc[3:2];
   assign w_adv_pc = {r_pc[31:4] + 28'd1, 4'b0000};

   assign w_unused_bits = redirect_pc[1:0];
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_cnt_nxt   = r_blk_cnt;
      if (redirect_valid) begin
         w_pc_nxt    = {redirect_pc[31:2], 2'b00};
         w_state_nxt = S_RUN;
      end else if (halt_req && r_state == S_RUN) begin
         w_state_nxt = S_HALT;
      end else if (!stall) begin
         if (r_state == S_BOOT) begin
            w_state_nxt = S_RUN;
         end
         if (w_accept) begin
            w_pc_nxt  = w_adv_pc;
            w_cnt_nxt = r_blk_cnt + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_BOOT;
         r_pc      <= RESET_PC;
         r_blk_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_pc      <= w_pc_nxt;
         r_blk_cnt <= w_cnt_nxt;
      end
   end

   assign f.fetch_pc = r_pc;
   assign f.cut_pos  = w_cut;
   assign f.pc_valid = w_pc_valid;
   assign blk_cnt    = r_blk_cnt;

endmodule
